// File: rtl/ps2_key_sequencer.sv
// Folds E0/F0 scan-code prefixes from the PS/2 receive FIFO into make/break key events.
// Optional macro PS2_TYPEMATIC_FILTER_EN drops repeated make codes of the key already held.
`timescale 1ns/1ps

module ps2_key_sequencer #(
    parameter logic [7:0] PREFIX_EXT = 8'hE0,
    parameter logic [7:0] PREFIX_BRK = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_ready,
    input  logic [7:0] kbd_data,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       key_held,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic [7:0] rel_cnt_bcd,
    output logic       ovf_seen
);

    typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_f, ext_d;
    logic       brk_f, brk_d;
    logic [7:0] evt_code_d;
    logic       evt_ext_d;
    logic       evt_brk_d;
    logic       key_held_d;
    logic [7:0] held_code_d;
    logic       held_ext_d;
    logic [7:0] rel_cnt_d;
    logic [7:0] rel_cnt_inc;
    logic       ovf_d;
    logic       typematic_drop;

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign typematic_drop = !brk_f && key_held && (byte_q == held_code) && (ext_f == held_ext);
`else
    assign typematic_drop = 1'b0;
`endif

    // Two-digit BCD increment, 99 wraps to 00
    always_comb begin
        rel_cnt_inc = rel_cnt_bcd;
        if (rel_cnt_bcd[3:0] == 4'd9) begin
            rel_cnt_inc[3:0] = 4'd0;
            rel_cnt_inc[7:4] = (rel_cnt_bcd[7:4] == 4'd9) ? 4'd0 : rel_cnt_bcd[7:4] + 4'd1;
        end else begin
            rel_cnt_inc[3:0] = rel_cnt_bcd[3:0] + 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        ext_d       = ext_f;
        brk_d       = brk_f;
        evt_code_d  = evt_code;
        evt_ext_d   = evt_ext;
        evt_brk_d   = evt_brk;
        key_held_d  = key_held;
        held_code_d = held_code;
        held_ext_d  = held_ext;
        rel_cnt_d   = rel_cnt_bcd;
        ovf_d       = ovf_seen | kbd_overflow;

        kbd_nextdata_n = (state_q != POP);
        evt_valid      = (state_q == EMIT);

        case (state_q)
            IDLE: begin
                if (kbd_ready) begin
                    byte_d  = kbd_data;
                    state_d = POP;
                end
            end
            POP: state_d = DECODE;
            DECODE: begin
                if (byte_q == PREFIX_EXT) begin
                    ext_d   = 1'b1;
                    state_d = IDLE;
                end else if (byte_q == PREFIX_BRK) begin
                    brk_d   = 1'b1;
                    state_d = IDLE;
                end else if (typematic_drop) begin
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    evt_code_d = byte_q;
                    evt_ext_d  = ext_f;
                    evt_brk_d  = brk_f;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                // Held-key tracking and release count commit on the accepting edge
                if (evt_ready) begin
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = IDLE;
                    if (!evt_brk) begin
                        held_code_d = evt_code;
                        held_ext_d  = evt_ext;
                        key_held_d  = 1'b1;
                    end else begin
                        if ((evt_code == held_code) && (evt_ext == held_ext))
                            key_held_d = 1'b0;
                        rel_cnt_d = rel_cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_q      <= 8'h00;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            evt_code    <= 8'h00;
            evt_ext     <= 1'b0;
            evt_brk     <= 1'b0;
            key_held    <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            rel_cnt_bcd <= 8'h00;
            ovf_seen    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            ext_f       <= ext_d;
            brk_f       <= brk_d;
            evt_code    <= evt_code_d;
            evt_ext     <= evt_ext_d;
            evt_brk     <= evt_brk_d;
            key_held    <= key_held_d;
            held_code   <= held_code_d;
            held_ext    <= held_ext_d;
            rel_cnt_bcd <= rel_cnt_d;
            ovf_seen    <= ovf_d;
        end
    end

endmodule
